// File: rtl/rob_retire_if.sv
// Bus bundle for rob_retire: slot descriptors in, completions in, retire writeback and occupancy out.
// master = pipeline side (front end + execution units), slave = reorder buffer.
interface rob_retire_if #(
    parameter int DATA_W = 32
);
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic              null_flag;
        logic [4:0]        rob_id;
    } pc_out_t;

    pc_out_t           alloc1;
    pc_out_t           alloc2;

    logic              cmpl1_valid;
    logic [4:0]        cmpl1_id;
    logic              cmpl1_wen;
    logic [4:0]        cmpl1_wreg;
    logic [DATA_W-1:0] cmpl1_wdata;
    logic              cmpl2_valid;
    logic [4:0]        cmpl2_id;
    logic              cmpl2_wen;
    logic [4:0]        cmpl2_wreg;
    logic [DATA_W-1:0] cmpl2_wdata;

    logic              ret1_valid;
    logic [DATA_W-1:0] ret1_pc;
    logic              ret1_wen;
    logic [4:0]        ret1_wreg;
    logic [DATA_W-1:0] ret1_wdata;
    logic              ret2_valid;
    logic [DATA_W-1:0] ret2_pc;
    logic              ret2_wen;
    logic [4:0]        ret2_wreg;
    logic [DATA_W-1:0] ret2_wdata;

    logic              stall;
    logic [5:0]        count;

    modport master (
        output alloc1, alloc2,
        output cmpl1_valid, cmpl1_id, cmpl1_wen, cmpl1_wreg, cmpl1_wdata,
        output cmpl2_valid, cmpl2_id, cmpl2_wen, cmpl2_wreg, cmpl2_wdata,
        input  ret1_valid, ret1_pc, ret1_wen, ret1_wreg, ret1_wdata,
        input  ret2_valid, ret2_pc, ret2_wen, ret2_wreg, ret2_wdata,
        input  stall, count
    );

    modport slave (
        input  alloc1, alloc2,
        input  cmpl1_valid, cmpl1_id, cmpl1_wen, cmpl1_wreg, cmpl1_wdata,
        input  cmpl2_valid, cmpl2_id, cmpl2_wen, cmpl2_wreg, cmpl2_wdata,
        output ret1_valid, ret1_pc, ret1_wen, ret1_wreg, ret1_wdata,
        output ret2_valid, ret2_pc, ret2_wen, ret2_wreg, ret2_wdata,
        output stall, count
    );
endinterface

// File: rtl/rob_retire.sv
// 32-entry reorder buffer: in-order allocate, out-of-order complete, in-order dual retire on the falling edge.
// Define ROB_CHECK_EN to compile in simulation checks for illegal allocate/complete traffic.
module rob_retire #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input  logic         clock,
    input  logic         reset,
    rob_retire_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]  ent_valid_q, ent_valid_d;
    logic [DEPTH-1:0]  ent_done_q,  ent_done_d;
    logic [DEPTH-1:0]  ent_wen_q,   ent_wen_d;
    logic [DATA_W-1:0] ent_pc_q    [DEPTH];
    logic [DATA_W-1:0] ent_pc_d    [DEPTH];
    logic [DATA_W-1:0] ent_wdata_q [DEPTH];
    logic [DATA_W-1:0] ent_wdata_d [DEPTH];
    logic [4:0]        ent_wreg_q  [DEPTH];
    logic [4:0]        ent_wreg_d  [DEPTH];

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              ret1_valid_q, ret1_valid_d;
    logic [DATA_W-1:0] ret1_pc_q,    ret1_pc_d;
    logic              ret1_wen_q,   ret1_wen_d;
    logic [4:0]        ret1_wreg_q,  ret1_wreg_d;
    logic [DATA_W-1:0] ret1_wdata_q, ret1_wdata_d;
    logic              ret2_valid_q, ret2_valid_d;
    logic [DATA_W-1:0] ret2_pc_q,    ret2_pc_d;
    logic              ret2_wen_q,   ret2_wen_d;
    logic [4:0]        ret2_wreg_q,  ret2_wreg_d;
    logic [DATA_W-1:0] ret2_wdata_q, ret2_wdata_d;

    logic              a1_req, a2_req, alloc_ok;
    logic [1:0]        n_req, n_alloc, n_ret;
    logic [CNT_W-1:0]  free_cnt;
    logic              ret1_fire, ret2_fire;
    logic [IDX_W-1:0]  head_p1;

    // Retire selection and allocation admission both look only at registered state.
    always_comb begin
        head_p1   = head_q + 1'b1;
        ret1_fire = ent_valid_q[head_q] & ent_done_q[head_q];
        ret2_fire = ret1_fire & ent_valid_q[head_p1] & ent_done_q[head_p1];
        n_ret     = {1'b0, ret1_fire} + {1'b0, ret2_fire};

        a1_req    = !bus.alloc1.null_flag;
        a2_req    = !bus.alloc2.null_flag;
        n_req     = {1'b0, a1_req} + {1'b0, a2_req};
        free_cnt  = CNT_W'(DEPTH) - count_q;
        alloc_ok  = CNT_W'(n_req) <= free_cnt;
        n_alloc   = alloc_ok ? n_req : 2'd0;
    end

    always_comb begin
        ent_valid_d = ent_valid_q;
        ent_done_d  = ent_done_q;
        ent_wen_d   = ent_wen_q;
        ent_pc_d    = ent_pc_q;
        ent_wdata_d = ent_wdata_q;
        ent_wreg_d  = ent_wreg_q;

        if (ret1_fire) ent_valid_d[head_q]  = 1'b0;
        if (ret2_fire) ent_valid_d[head_p1] = 1'b0;

        if (alloc_ok && a1_req) begin
            ent_valid_d[bus.alloc1.rob_id] = 1'b1;
            ent_done_d[bus.alloc1.rob_id]  = 1'b0;
            ent_pc_d[bus.alloc1.rob_id]    = bus.alloc1.pc;
        end
        if (alloc_ok && a2_req) begin
            ent_valid_d[bus.alloc2.rob_id] = 1'b1;
            ent_done_d[bus.alloc2.rob_id]  = 1'b0;
            ent_pc_d[bus.alloc2.rob_id]    = bus.alloc2.pc;
        end

        if (bus.cmpl1_valid) begin
            ent_done_d[bus.cmpl1_id]  = 1'b1;
            ent_wen_d[bus.cmpl1_id]   = bus.cmpl1_wen;
            ent_wreg_d[bus.cmpl1_id]  = bus.cmpl1_wreg;
            ent_wdata_d[bus.cmpl1_id] = bus.cmpl1_wdata;
        end
        if (bus.cmpl2_valid) begin
            ent_done_d[bus.cmpl2_id]  = 1'b1;
            ent_wen_d[bus.cmpl2_id]   = bus.cmpl2_wen;
            ent_wreg_d[bus.cmpl2_id]  = bus.cmpl2_wreg;
            ent_wdata_d[bus.cmpl2_id] = bus.cmpl2_wdata;
        end

        head_d  = head_q + IDX_W'(n_ret);
        tail_d  = tail_q + IDX_W'(n_alloc);
        count_d = count_q + CNT_W'(n_alloc) - CNT_W'(n_ret);

        // Writeback fields are zeroed whenever the slot is not retiring.
        ret1_valid_d = ret1_fire;
        ret1_pc_d    = ret1_fire ? ent_pc_q[head_q]    : '0;
        ret1_wen_d   = ret1_fire & ent_wen_q[head_q];
        ret1_wreg_d  = ret1_fire ? ent_wreg_q[head_q]  : '0;
        ret1_wdata_d = ret1_fire ? ent_wdata_q[head_q] : '0;
        ret2_valid_d = ret2_fire;
        ret2_pc_d    = ret2_fire ? ent_pc_q[head_p1]    : '0;
        ret2_wen_d   = ret2_fire & ent_wen_q[head_p1];
        ret2_wreg_d  = ret2_fire ? ent_wreg_q[head_p1]  : '0;
        ret2_wdata_d = ret2_fire ? ent_wdata_q[head_p1] : '0;
    end

    always_ff @(negedge clock) begin
        if (!reset) begin
            ent_valid_q  <= '0;
            ent_done_q   <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ret1_valid_q <= 1'b0;
            ret1_pc_q    <= '0;
            ret1_wen_q   <= 1'b0;
            ret1_wreg_q  <= '0;
            ret1_wdata_q <= '0;
            ret2_valid_q <= 1'b0;
            ret2_pc_q    <= '0;
            ret2_wen_q   <= 1'b0;
            ret2_wreg_q  <= '0;
            ret2_wdata_q <= '0;
        end else begin
            ent_valid_q  <= ent_valid_d;
            ent_done_q   <= ent_done_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ret1_valid_q <= ret1_valid_d;
            ret1_pc_q    <= ret1_pc_d;
            ret1_wen_q   <= ret1_wen_d;
            ret1_wreg_q  <= ret1_wreg_d;
            ret1_wdata_q <= ret1_wdata_d;
            ret2_valid_q <= ret2_valid_d;
            ret2_pc_q    <= ret2_pc_d;
            ret2_wen_q   <= ret2_wen_d;
            ret2_wreg_q  <= ret2_wreg_d;
            ret2_wdata_q <= ret2_wdata_d;
        end
    end

    // Payload storage is qualified by the valid/done bits, so it needs no reset.
    always_ff @(negedge clock) begin
        ent_wen_q   <= ent_wen_d;
        ent_pc_q    <= ent_pc_d;
        ent_wdata_q <= ent_wdata_d;
        ent_wreg_q  <= ent_wreg_d;
    end

    assign bus.ret1_valid = ret1_valid_q;
    assign bus.ret1_pc    = ret1_pc_q;
    assign bus.ret1_wen   = ret1_wen_q;
    assign bus.ret1_wreg  = ret1_wreg_q;
    assign bus.ret1_wdata = ret1_wdata_q;
    assign bus.ret2_valid = ret2_valid_q;
    assign bus.ret2_pc    = ret2_pc_q;
    assign bus.ret2_wen   = ret2_wen_q;
    assign bus.ret2_wreg  = ret2_wreg_q;
    assign bus.ret2_wdata = ret2_wdata_q;
    assign bus.stall      = count_q >= CNT_W'(DEPTH - 1);
    assign bus.count      = 6'(count_q);

`ifdef ROB_CHECK_EN
    logic [IDX_W-1:0] exp_id2;
    assign exp_id2 = a1_req ? tail_q + 1'b1 : tail_q;

    always_ff @(negedge clock) begin
        if (reset) begin
            if ((a1_req && bus.alloc1.rob_id != tail_q) ||
                (a2_req && bus.alloc2.rob_id != exp_id2)) begin
                $display("Fatal: allocation id does not match tail %0d", tail_q);
                $stop;
            end
            if (!alloc_ok) begin
                $display("Fatal: allocation of %0d entries with %0d free", n_req, free_cnt);
                $stop;
            end
            if ((bus.cmpl1_valid && (!ent_valid_q[bus.cmpl1_id] || ent_done_q[bus.cmpl1_id])) ||
                (bus.cmpl2_valid && (!ent_valid_q[bus.cmpl2_id] || ent_done_q[bus.cmpl2_id]))) begin
                $display("Fatal: completion to an entry that is not pending");
                $stop;
            end
            if ((bus.cmpl1_valid && a1_req && bus.cmpl1_id == bus.alloc1.rob_id) ||
                (bus.cmpl1_valid && a2_req && bus.cmpl1_id == bus.alloc2.rob_id) ||
                (bus.cmpl2_valid && a1_req && bus.cmpl2_id == bus.alloc1.rob_id) ||
                (bus.cmpl2_valid && a2_req && bus.cmpl2_id == bus.alloc2.rob_id)) begin
                $display("Fatal: completion and allocation of the same id in one cycle");
                $stop;
            end
        end
    end
`endif
endmodule

// File: doc/rob_retire.md
# rob_retire

Reorder buffer for the dual-issue MIPS core. It consumes the two per-cycle slot descriptors (pc, null_flag, rob_id) produced by the program counter block and records them in program order. It collects out-of-order completions from the execution units and retires up to two finished entries per cycle, in order, to the register-file writeback. It also drives the stall signal that tells the fetch front end when free ROB entries run short.

## Interface
- DEPTH, 32, number of entries. Fixed to 2^5 to match the 5-bit rob_id space.
- DATA_W, 32, width of the pc and result fields.

- clock  in  1  pipeline clock. All state updates on the falling edge, matching the PC block.
- reset  in  1  synchronous, active-low reset. Sampled on the falling edge of clock.
- alloc1, alloc2  in  PC_out_t (pc 32, null_flag 1, rob_id 5)  slot descriptors. null_flag=1 means no allocation on that port.
- cmpl1_valid, cmpl2_valid  in  1  completion strobe for each execution port.
- cmpl1_id, cmpl2_id  in  5  ROB entry being completed.
- cmpl1_wen, cmpl2_wen  in  1  the instruction writes a GPR.
- cmpl1_wreg, cmpl2_wreg  in  5  destination register.
- cmpl1_wdata, cmpl2_wdata  in  32  result value.
- ret1_valid, ret2_valid  out  1  a retire is issued this cycle. ret2_valid implies ret1_valid.
- ret1_pc, ret2_pc  out  32  pc of the retiring instruction.
- ret1_wen, ret2_wen  out  1  writeback enable, already gated by retire valid.
- ret1_wreg, ret2_wreg  out  5  writeback register.
- ret1_wdata, ret2_wdata  out  32  writeback value.
- stall  out  1  fewer than 2 free entries. Upstream must block both slots.
- count  out  6  number of occupied entries, 0..32.

## Operation
- Per-entry state: valid, done, pc, wen, wreg, wdata. Pointers: head (5 bits) and tail (5 bits), both wrap modulo 32. count is 6 bits.
- Allocation:
  - Each port with null_flag=0 writes its entry at index rob_id: valid=1, done=0, pc stored.
  - Non-null ids arrive consecutive starting at tail. If only alloc2 is non-null, its id equals tail.
  - tail advances by the number of non-null ports (0, 1 or 2).
- Completion:
  - A valid completion sets done=1 and stores wen, wreg and wdata.
  - Two completions to distinct ids in the same cycle are both accepted.
  - Completing an entry in the same cycle it is allocated is illegal.
- Retire selection, evaluated from registered state:
  - Slot 1 fires if entry[head] has valid and done set.
  - Slot 2 fires if slot 1 fires and entry[head+1] has valid and done set.
  - Retiring entries get valid=0, and head advances by the number retired.
  - Retire fields are registered, so they appear on the ret* outputs one edge after selection.
- count_next = count + allocated − retired. Simultaneous alloc and retire are netted in the same edge.
- stall = (count >= DEPTH−1), combinational from registered count.
- An allocation presented while free entries are fewer than the non-null ports is dropped: no state change for that port.
- Reset forces head=0, tail=0, count=0, every valid and done bit to 0, and every output to 0, including stall. Reset mid-operation discards pending entries without retiring them. The first post-reset allocation is id 0, matching the PC block's rob_id reset.

## Timing
- Allocation at edge k: the entry is occupied after edge k, and count/stall reflect it in cycle k+1.
- Completion sampled at edge k: the entry is eligible for retire selection in cycle k+1. At edge k+1 the ret* outputs register it and become visible for one cycle.
- Minimum completion-to-writeback latency: 2 falling edges.
- Retire is strictly in program order. A not-done head entry blocks all younger done entries.
- Wrap-around: head+1 and tail+1 wrap 31→0. A 2-wide retire across the wrap is allowed.

## Configuration
- ROB_CHECK_EN defined: simulation checks are compiled in. Each check executes $display("Fatal: ...") and then $stop. The checks cover:
  - allocation id ≠ expected tail;
  - allocation while insufficient free entries;
  - completion to an entry with valid=0 or done=1;
  - completion and allocation of the same id in one cycle.
- ROB_CHECK_EN undefined: no checks. Illegal events follow the drop/overwrite behaviour above silently.

## Test plan
- Reset: reset=0 for 2 edges, then 1 → ret1_valid=ret2_valid=0, count=0, stall=0.
- Out-of-order completion:
  - Stimulus: alloc ids 0,1 with pc 0x3000,0x3004; complete id 1 (wreg 8, wdata 0x55); two idle cycles; complete id 0 (wreg 9, wdata 0x66).
  - Response: no retire until id 0 completes. Then one cycle with ret1 = (0x3000, 9, 0x66) and ret2 = (0x3004, 8, 0x55); count returns to 0.
- Full: allocate 31 entries with no completions → stall=1 once count=31. A further 2-slot allocation is dropped and count stays 31.
- Wrap:
  - Stimulus: cycle pointers to head=tail=30; alloc ids 30,31, then 0,1; complete all four.
  - Response: retires in order 30,31 then 0,1; final head=tail=2.
- Simultaneous events: with count=20, in one cycle allocate 2 and retire 2 → count stays 20, stall=0.
- Reset mid-operation: with 5 pending entries, assert reset → count=0. The next alloc of id 0 is accepted. With ROB_CHECK_EN, an alloc of id 5 when tail=3 triggers the fatal $stop.
